// File: rtl/clock1_pkg.sv
// Shared definitions for the clock1 digital clock: mode encoding used by the
// time-setting controller and the display mux, and button line indices.
package clock1_pkg;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'd0,
        MODE_HOUR = 2'd1,
        MODE_MIN  = 2'd2,
        MODE_SEC  = 2'd3
    } mode_e;

    localparam int BTN_SET  = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_EXIT = 2;

    // {hour,min,sec} mask of the field being edited in a given mode
    function automatic logic [2:0] field_mask(input mode_e m);
        logic [2:0] mask;
        case (m)
            MODE_HOUR: mask = 3'b100;
            MODE_MIN:  mask = 3'b010;
            MODE_SEC:  mask = 3'b001;
            default:   mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/press_det.sv
// Press detector for one debounced pulse line. The debouncer repeats pulses
// while a button is held, so a pulse only counts as a new press after GAP
// cycles of silence on the line.
module press_det #(
    parameter int GAP = 1500000
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic press
);

    localparam int             GW    = $clog2(GAP + 1);
    localparam logic [GW-1:0]  GAP_V = GW'(GAP);

    logic [GW-1:0] gap_q, gap_d;

    // Cycles since the last pulse, saturating at GAP; any pulse restarts it
    always_comb begin
        gap_d = gap_q;
        if (pulse) begin
            gap_d = '0;
        end else if (gap_q != GAP_V) begin
            gap_d = gap_q + 1'b1;
        end
    end

    // Reset to GAP so the first pulse after reset is treated as a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q <= GAP_V;
        end else begin
            gap_q <= gap_d;
        end
    end

    assign press = pulse && (gap_q == GAP_V);

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller for clock1: mode FSM driven by SET/UP/EXIT presses,
// increment/clear strobes with UP auto-repeat, run enable and blink masks.
module time_set_ctrl
    import clock1_pkg::*;
#(
    parameter int GAP         = 1500000,
    parameter int HOLD_PULSES = 20,
    parameter int REP_PULSES  = 4,
    parameter int BLINK_DIV   = 12500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] BIN,
    output logic       RUN_EN,
    output logic       INC_HOUR,
    output logic       INC_MIN,
    output logic       SEC_CLR,
    output logic [2:0] BLINK,
    output logic [1:0] MODE
);

    localparam int RW = $clog2(HOLD_PULSES + 1);
    localparam int PW = $clog2(REP_PULSES + 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [RW-1:0] HOLD_V     = RW'(HOLD_PULSES);
    localparam logic [PW-1:0] REP_LAST   = PW'(REP_PULSES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic set_press, up_press, exit_press;
    logic up_pulse;

    mode_e         mode_q, mode_d;
    logic          mode_chg;
    logic [RW-1:0] rep_q, rep_d;
    logic [PW-1:0] rph_q, rph_d;
    logic          rep_fire;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic          run_en_q, run_en_d;
    logic          inc_hour_q, inc_hour_d;
    logic          inc_min_q, inc_min_d;
    logic          sec_clr_q, sec_clr_d;
    logic [2:0]    blink_q, blink_d;

    assign up_pulse = BIN[BTN_UP];

    press_det #(.GAP(GAP)) u_set_det (
        .clk   (CLK),
        .rst   (RST),
        .pulse (BIN[BTN_SET]),
        .press (set_press)
    );

    press_det #(.GAP(GAP)) u_up_det (
        .clk   (CLK),
        .rst   (RST),
        .pulse (BIN[BTN_UP]),
        .press (up_press)
    );

    press_det #(.GAP(GAP)) u_exit_det (
        .clk   (CLK),
        .rst   (RST),
        .pulse (BIN[BTN_EXIT]),
        .press (exit_press)
    );

    // Mode next-state: EXIT leaves any set mode, otherwise SET steps round
    always_comb begin
        mode_d = mode_q;
        if (exit_press && (mode_q != MODE_RUN)) begin
            mode_d = MODE_RUN;
        end else if (set_press) begin
            case (mode_q)
                MODE_RUN:  mode_d = MODE_HOUR;
                MODE_HOUR: mode_d = MODE_MIN;
                MODE_MIN:  mode_d = MODE_SEC;
                default:   mode_d = MODE_RUN;
            endcase
        end
    end

    // Mode state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q <= MODE_RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    // UP auto-repeat: count held pulses up to HOLD_PULSES, then every REP_PULSES
    always_comb begin
        rep_d    = rep_q;
        rph_d    = rph_q;
        rep_fire = 1'b0;
        if (up_pulse) begin
            if (up_press) begin
                rep_d = '0;
                rph_d = '0;
            end else if (rep_q != HOLD_V) begin
                rep_d    = rep_q + 1'b1;
                rep_fire = (rep_d == HOLD_V);
            end else if (rph_q == REP_LAST) begin
                rph_d    = '0;
                rep_fire = 1'b1;
            end else begin
                rph_d = rph_q + 1'b1;
            end
        end
    end

    // Strobes, run enable and blink; strobes are suppressed on a mode change
    // and the blink phase restarts so a newly selected field shows first
    always_comb begin
        mode_chg   = (mode_d != mode_q);
        run_en_d   = (mode_d == MODE_RUN);
        inc_hour_d = (up_press || rep_fire) && !mode_chg && (mode_q == MODE_HOUR);
        inc_min_d  = (up_press || rep_fire) && !mode_chg && (mode_q == MODE_MIN);
        sec_clr_d  = up_press && !mode_chg && (mode_q == MODE_SEC);
        bcnt_d     = bcnt_q + 1'b1;
        phase_d    = phase_q;
        if (mode_chg || (mode_d == MODE_RUN)) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
        blink_d = field_mask(mode_d) & {3{phase_d}};
    end

    // Registered outputs and datapath counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rep_q      <= '0;
            rph_q      <= '0;
            bcnt_q     <= '0;
            phase_q    <= 1'b0;
            run_en_q   <= 1'b1;
            inc_hour_q <= 1'b0;
            inc_min_q  <= 1'b0;
            sec_clr_q  <= 1'b0;
            blink_q    <= 3'b000;
        end else begin
            rep_q      <= rep_d;
            rph_q      <= rph_d;
            bcnt_q     <= bcnt_d;
            phase_q    <= phase_d;
            run_en_q   <= run_en_d;
            inc_hour_q <= inc_hour_d;
            inc_min_q  <= inc_min_d;
            sec_clr_q  <= sec_clr_d;
            blink_q    <= blink_d;
        end
    end

    assign MODE     = mode_q;
    assign RUN_EN   = run_en_q;
    assign INC_HOUR = inc_hour_q;
    assign INC_MIN  = inc_min_q;
    assign SEC_CLR  = sec_clr_q;
    assign BLINK    = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with small timing parameters.
module tb_time_set_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] bin;
    logic       run_en, inc_hour, inc_min, sec_clr;
    logic [2:0] blink;
    logic [1:0] mode;

    int checks   = 0;
    int failures = 0;

    int n_hour = 0, n_min = 0, n_sec = 0;
    int long_strobe = 0, runen_bad = 0;
    logic prev_h = 1'b0, prev_m = 1'b0, prev_s = 1'b0;

    time_set_ctrl #(
        .GAP         (10),
        .HOLD_PULSES (3),
        .REP_PULSES  (2),
        .BLINK_DIV   (8)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .BIN      (bin),
        .RUN_EN   (run_en),
        .INC_HOUR (inc_hour),
        .INC_MIN  (inc_min),
        .SEC_CLR  (sec_clr),
        .BLINK    (blink),
        .MODE     (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counters and cycle-by-cycle property watch
    always @(negedge clk) begin
        if (rst) begin
            prev_h = 1'b0;
            prev_m = 1'b0;
            prev_s = 1'b0;
        end else begin
            n_hour = n_hour + int'(inc_hour);
            n_min  = n_min + int'(inc_min);
            n_sec  = n_sec + int'(sec_clr);
            if ((inc_hour && prev_h) || (inc_min && prev_m) || (sec_clr && prev_s))
                long_strobe = long_strobe + 1;
            if (run_en != (mode == 2'd0))
                runen_bad = runen_bad + 1;
            prev_h = inc_hour;
            prev_m = inc_min;
            prev_s = sec_clr;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle pulse; returns at the sample point right after the edge that saw it
    task automatic pulse(input logic [2:0] m);
        @(negedge clk);
        bin = m;
        @(negedge clk);
        bin = 3'b000;
    endtask

    int base_h, base_m, base_s;
    int hitmask;
    int exp_mode [4] = '{1, 2, 3, 0};

    initial begin
        rst = 1'b1;
        bin = 3'b000;
        idle(3);
        check("rst_mode", int'(mode), 0);
        check("rst_run_en", int'(run_en), 1);
        check("rst_strobes", int'({inc_hour, inc_min, sec_clr}), 0);
        check("rst_blink", int'(blink), 0);
        rst = 1'b0;
        idle(5);

        // 1. Mode cycling
        base_h = n_hour; base_m = n_min; base_s = n_sec;
        for (int i = 0; i < 4; i++) begin
            pulse(3'b001);
            check($sformatf("cycle_mode%0d", i), int'(mode), exp_mode[i]);
            check($sformatf("cycle_run_en%0d", i), int'(run_en), (exp_mode[i] == 0) ? 1 : 0);
            idle(20);
        end
        check("cycle_no_strobes", (n_hour - base_h) + (n_min - base_m) + (n_sec - base_s), 0);

        // 2. Single increment in SET_MIN
        pulse(3'b001); idle(20);
        pulse(3'b001); idle(20);
        check("t2_mode", int'(mode), 2);
        base_h = n_hour; base_m = n_min; base_s = n_sec;
        pulse(3'b010);
        check("t2_inc_min", int'(inc_min), 1);
        check("t2_inc_hour", int'(inc_hour), 0);
        check("t2_sec_clr", int'(sec_clr), 0);
        idle(1);
        check("t2_inc_min_off", int'(inc_min), 0);
        idle(20);
        check("t2_min_count", n_min - base_m, 1);
        check("t2_other_count", (n_hour - base_h) + (n_sec - base_s), 0);

        // 3. Auto-repeat in SET_HOUR: pulses 1,4,6,8,10 strobe
        pulse(3'b001); idle(20);
        pulse(3'b001); idle(20);
        pulse(3'b001); idle(20);
        check("t3_mode", int'(mode), 1);
        base_h = n_hour;
        hitmask = 0;
        for (int p = 0; p < 10; p++) begin
            pulse(3'b010);
            if (inc_hour) hitmask = hitmask | (1 << p);
            idle(3);
        end
        check("t3_hit_pattern", hitmask, 'h2A9);
        check("t3_hour_count", n_hour - base_h, 5);
        idle(20);

        // 4. Held UP in SET_SEC clears once; held SET advances once
        pulse(3'b001); idle(20);
        pulse(3'b001); idle(20);
        check("t4_mode", int'(mode), 3);
        base_h = n_hour; base_m = n_min; base_s = n_sec;
        for (int p = 0; p < 6; p++) begin
            pulse(3'b010);
            idle(3);
        end
        idle(20);
        check("t4_sec_count", n_sec - base_s, 1);
        check("t4_no_inc", (n_hour - base_h) + (n_min - base_m), 0);
        pulse(3'b001);
        check("t4_set_first", int'(mode), 0);
        idle(3);
        for (int p = 0; p < 4; p++) begin
            pulse(3'b001);
            idle(3);
        end
        check("t4_set_held", int'(mode), 0);
        idle(20);

        // 5. Simultaneous events
        pulse(3'b001); idle(20);
        pulse(3'b001); idle(20);
        check("t5_mode_pre", int'(mode), 2);
        base_h = n_hour; base_m = n_min; base_s = n_sec;
        pulse(3'b101);
        check("t5_set_exit_mode", int'(mode), 0);
        idle(20);
        pulse(3'b001); idle(20);
        check("t5_mode_hour", int'(mode), 1);
        pulse(3'b011);
        check("t5_set_up_mode", int'(mode), 2);
        check("t5_set_up_inc", int'({inc_hour, inc_min}), 0);
        idle(20);
        check("t5_no_strobes", (n_hour - base_h) + (n_min - base_m) + (n_sec - base_s), 0);

        // 6. Blink after entering SET_HOUR
        pulse(3'b001); idle(20);
        pulse(3'b001); idle(20);
        pulse(3'b001);
        check("t6_mode", int'(mode), 1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("blink%0d", i), int'(blink), (i < 8) ? 0 : 4);
            @(negedge clk);
        end

        // 6. Reset in the middle of a held UP
        pulse(3'b010);
        check("t6_first_up", int'(inc_hour), 1);
        idle(3);
        pulse(3'b010); idle(3);
        pulse(3'b010); idle(1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_mode", int'(mode), 0);
        check("t6_rst_run_en", int'(run_en), 1);
        check("t6_rst_strobes", int'({inc_hour, inc_min, sec_clr}), 0);
        check("t6_rst_blink", int'(blink), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulse(3'b001);
        check("t6_post_rst_mode", int'(mode), 1);
        idle(1);
        pulse(3'b010);
        check("t6_post_rst_press", int'(inc_hour), 1);
        idle(5);

        check("strobe_one_cycle", long_strobe, 0);
        check("run_en_tracks_mode", runen_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
